// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC -> combinational imem -> FIFO_DEPTH prefetch FIFO -> decode; word at head 1 cycle after its address.
// Fetch stalls when the FIFO is full and not popping; redirect flushes. FETCH_PERF_EN adds fetch/stall counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [32:0]      IMEM_LIMIT = 33'(IMEM_BYTES);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_FAULT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      pc;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  entry_t           hold_q;
  entry_t           head;
  logic             pc_ok;
  logic             redirect_ok;
  logic             full;
  logic             pop;
  logic             push;

  // 33-bit compare so a pc near 2^32 cannot wrap into range
  assign pc_ok       = (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd3) < IMEM_LIMIT);
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) &&
                       (({1'b0, redirect_pc} + 33'd3) < IMEM_LIMIT);

  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign full        = (count == DEPTH_C);
  assign pop         = instr_valid && instr_ready;
  assign push        = !redirect_valid && (state == ST_RUN) && pc_ok && (!full || pop);
  assign fetch_fault = (state == ST_FAULT);

  // When empty the outputs replay whatever was shown last cycle
  assign head     = instr_valid ? mem[rd_ptr] : hold_q;
  assign instr    = head.word;
  assign instr_pc = head.pc;

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (redirect_ok || (state != ST_FAULT)) begin
        state_nxt = halt ? ST_HALTED : ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (!pc_ok) begin
            state_nxt = ST_FAULT;
          end else if (halt) begin
            state_nxt = ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (!halt) begin
            state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      state  <= state_nxt;
      hold_q <= head;
      if (redirect_valid) begin
        pc     <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= {pc, imem_instr};
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if ((state == ST_RUN) && full && !pop) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
